ov9281_dvp_tx: RTL and testbench

DVP-style frame transmitter that replays a stored frame in the same signalling a camera capture path accepts. Pops 32-bit words from a first-word-fall-through read FIFO fed by DDR. Serialises each word into four bytes, least-significant byte first. Drives `dvp_vsync` / `dvp_href` / `dvp_data` with programmable active and blanking geometry, so a capture block can loop back a full frame for bring-up and regression.

---
 rtl/ov9281_dvp_tx.sv | 187 ++++++++++++++++++
 tb/tb_ov9281_dvp_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov9281_dvp_tx.sv
// DVP frame transmitter: replays 32-bit FIFO words as LSB-first bytes with vsync/href framing.
// Define OV9281_DVP_TX_PATTERN_EN to replace FIFO replay with a column^line test pattern.
module ov9281_dvp_tx #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_BLANK     = 64,
  parameter int V_ACTIVE    = 800,
  parameter int VSYNC_LINES = 2,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic        camera_pclk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        rfifo_empty,
  input  logic [31:0] rfifo_data,
  output logic        rfifo_req,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        underflow
);

  localparam int LINE_LEN = H_ACTIVE + H_BLANK;
  localparam int CW       = $clog2(LINE_LEN + 1);
  localparam int LW       = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);

  localparam logic [CW-1:0] COL_LAST    = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] ACT_LAST    = CW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] VSYNC_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] BACK_LAST   = LW'(V_BACK - 1);
  localparam logic [LW-1:0] ACTIVE_LAST = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] FRONT_LAST  = LW'(V_FRONT - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACT, HBLANK, VFRONT} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [1:0]    byte_idx;
  logic          end_flag;
  logic          col_last;
  logic [7:0]    next_byte;

  assign col_last = (col == COL_LAST);

`ifdef OV9281_DVP_TX_PATTERN_EN
  logic unused_fifo;
  assign unused_fifo = ^{rfifo_empty, rfifo_data};
  assign rfifo_req   = 1'b0;
  assign underflow   = 1'b0;

  always_comb begin
    next_byte = 8'(col) ^ 8'(line);
  end
`else
  logic [31:0] word;
  logic        word_ok;

  // Pop only a word that was actually latched, so a late refill is never consumed unsent.
  assign rfifo_req = (state == ACT) && (byte_idx == 2'd3) && word_ok && !rfifo_empty;

  always_comb begin
    next_byte = 8'h00;
    if (byte_idx == 2'd0) begin
      next_byte = rfifo_empty ? 8'h00 : rfifo_data[7:0];
    end else if (word_ok) begin
      next_byte = word[{byte_idx, 3'b000} +: 8];
    end
  end
`endif

  always_ff @(posedge camera_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      line       <= '0;
      byte_idx   <= 2'd0;
      end_flag   <= 1'b0;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      frame_done <= 1'b0;
`ifndef OV9281_DVP_TX_PATTERN_EN
      word       <= 32'h0;
      word_ok    <= 1'b0;
      underflow  <= 1'b0;
`endif
    end else begin
      end_flag   <= 1'b0;
      dvp_vsync  <= (state == VSYNC);
      dvp_href   <= (state == ACT);
      dvp_data   <= (state == ACT) ? next_byte : 8'h00;
      frame_done <= end_flag;

      case (state)
        IDLE: begin
          if (init_done) begin
            state <= VSYNC;
            col   <= '0;
            line  <= '0;
          end
        end

        VSYNC: begin
          if (col_last) begin
            col <= '0;
            if (line == VSYNC_LAST) begin
              line  <= '0;
              state <= VBACK;
            end else begin
              line <= line + LW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end

        VBACK: begin
          if (col_last) begin
            col <= '0;
            if (line == BACK_LAST) begin
              line     <= '0;
              byte_idx <= 2'd0;
              state    <= ACT;
            end else begin
              line <= line + LW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end

        ACT: begin
          byte_idx <= byte_idx + 2'd1;
          col      <= col + CW'(1);
          if (col == ACT_LAST) begin
            state <= HBLANK;
          end
`ifndef OV9281_DVP_TX_PATTERN_EN
          if (byte_idx == 2'd0) begin
            word    <= rfifo_data;
            word_ok <= !rfifo_empty;
            if (rfifo_empty) begin
              underflow <= 1'b1;
            end
          end
`endif
        end

        HBLANK: begin
          if (col_last) begin
            col      <= '0;
            byte_idx <= 2'd0;
            if (line == ACTIVE_LAST) begin
              line  <= '0;
              state <= VFRONT;
            end else begin
              line  <= line + LW'(1);
              state <= ACT;
            end
          end else begin
            col <= col + CW'(1);
          end
        end

        VFRONT: begin
          if (col_last) begin
            col <= '0;
            if (line == FRONT_LAST) begin
              line     <= '0;
              end_flag <= 1'b1;
              state    <= init_done ? VSYNC : IDLE;
            end else begin
              line <= line + LW'(1);
            end
          end else begin
            col <= col + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov9281_dvp_tx.sv
// Scoreboard bench for ov9281_dvp_tx on an 8x2 active geometry (frame = 60 clocks).
module tb_ov9281_dvp_tx;

  localparam int FRAME = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        rfifo_empty = 1'b1;
  logic [31:0] rfifo_data = 32'hDEADBEEF;
  logic        rfifo_req;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_done;
  logic        underflow;

  always #5 clk = ~clk;

  ov9281_dvp_tx #(
    .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(2),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .camera_pclk(clk),
    .rst_n(rst_n),
    .init_done(init_done),
    .rfifo_empty(rfifo_empty),
    .rfifo_data(rfifo_data),
    .rfifo_req(rfifo_req),
    .dvp_vsync(dvp_vsync),
    .dvp_href(dvp_href),
    .dvp_data(dvp_data),
    .frame_done(frame_done),
    .underflow(underflow)
  );

  int total = 0;
  int bad = 0;
  int pop_cnt = 0;
  int pop_empty = 0;
  int blank_nz = 0;

  logic [31:0] fq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic        uf_q[$];
  int          vs_rise[$];
  int          vs_fall[$];
  int          hr_rise[$];
  int          hr_fall[$];
  int          fd_q[$];
  logic        prev_vs;
  logic        prev_hr;

  // FWFT FIFO model: pop on the active edge, head presented on the falling edge.
  always @(posedge clk) begin
    if (rfifo_req) begin
      pop_cnt++;
      if (fq.size() == 0) pop_empty++;
      else void'(fq.pop_front());
    end
  end

  always @(negedge clk) begin
    rfifo_empty = (fq.size() == 0);
    rfifo_data  = (fq.size() == 0) ? 32'hDEADBEEF : fq[0];
  end

  task automatic clear_obs();
    exp_q.delete(); obs_q.delete(); uf_q.delete();
    vs_rise.delete(); vs_fall.delete(); hr_rise.delete(); hr_fall.delete(); fd_q.delete();
    blank_nz = 0; pop_cnt = 0; pop_empty = 0;
    prev_vs = dvp_vsync; prev_hr = dvp_href;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    init_done = 1'b0;
    fq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_obs();
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic observe(input int ncyc, input int drop_at);
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == drop_at) init_done = 1'b0;
      if (dvp_vsync && !prev_vs) vs_rise.push_back(i);
      if (!dvp_vsync && prev_vs) vs_fall.push_back(i);
      if (dvp_href && !prev_hr) hr_rise.push_back(i);
      if (!dvp_href && prev_hr) hr_fall.push_back(i);
      if (frame_done) fd_q.push_back(i);
      if (dvp_href && !dvp_vsync) begin
        obs_q.push_back(dvp_data);
        uf_q.push_back(underflow);
      end
      if (!dvp_href && dvp_data !== 8'h00) blank_nz++;
      prev_vs = dvp_vsync;
      prev_hr = dvp_href;
    end
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    do_reset();
    outs = {dvp_vsync, dvp_href, dvp_data, frame_done, underflow, rfifo_req};
    total++;
    if (outs !== 13'h0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", outs); end
    observe(20, 0);
    total++;
    if (vs_rise.size() != 0) begin bad++; $display("FAIL reset_idle_vsync got=%0d want=0", vs_rise.size()); end
    $display("reset: outputs=%0h idle_vsync_rises=%0d", outs, vs_rise.size());
  endtask

`ifdef OV9281_DVP_TX_PATTERN_EN
  task automatic test_pattern();
    do_reset();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 8; c++) exp_q.push_back(8'(c ^ l));
    init_done = 1'b1;
    observe(70, 0);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL pat_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL pat_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
      else $display("pattern byte %0d = %02h", i, obs_q[i]);
    end
    total++;
    if (pop_cnt != 0) begin bad++; $display("FAIL pat_req got=%0d want=0", pop_cnt); end
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL pat_underflow got=%b want=0", underflow); end
  endtask
`else
  task automatic test_basic();
    int d;
    do_reset();
    for (int w = 0; w < 4; w++) push_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    init_done = 1'b1;
    observe(70, 0);
    total++;
    d = (vs_rise.size() > 0) ? vs_rise[0] : -1;
    if (d != 2) begin bad++; $display("FAIL basic_vsync_start got=%0d want=2", d); end
    total++;
    d = (vs_rise.size() > 0 && vs_fall.size() > 0) ? vs_fall[0] - vs_rise[0] : -1;
    if (d != 12) begin bad++; $display("FAIL basic_vsync_width got=%0d want=12", d); end
    total++;
    d = (vs_fall.size() > 0 && hr_rise.size() > 0) ? hr_rise[0] - vs_fall[0] : -1;
    if (d != 12) begin bad++; $display("FAIL basic_vback got=%0d want=12", d); end
    total++;
    d = (hr_rise.size() > 0 && hr_fall.size() > 0) ? hr_fall[0] - hr_rise[0] : -1;
    if (d != 8) begin bad++; $display("FAIL basic_href_width got=%0d want=8", d); end
    total++;
    d = (hr_rise.size() > 1 && hr_fall.size() > 0) ? hr_rise[1] - hr_fall[0] : -1;
    if (d != 4) begin bad++; $display("FAIL basic_hblank got=%0d want=4", d); end
    total++;
    if (obs_q.size() != 16) begin bad++; $display("FAIL basic_count got=%0d want=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
      else $display("basic byte %0d = %02h", i, obs_q[i]);
    end
    total++;
    if (pop_cnt != 4) begin bad++; $display("FAIL basic_pops got=%0d want=4", pop_cnt); end
    total++;
    d = (fd_q.size() == 1 && vs_rise.size() > 0) ? fd_q[0] - vs_rise[0] : -1;
    if (d != FRAME) begin bad++; $display("FAIL basic_frame_done got=%0d want=%0d", d, FRAME); end
    total++;
    if (blank_nz != 0) begin bad++; $display("FAIL basic_blank_data got=%0d want=0", blank_nz); end
  endtask

  task automatic test_underflow();
    do_reset();
    push_word(32'hDDCCBBAA);
    for (int i = 0; i < 12; i++) exp_q.push_back(8'h00);
    init_done = 1'b1;
    observe(62, 0);
    total++;
    if (obs_q.size() != 16) begin bad++; $display("FAIL uf_count got=%0d want=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i] || uf_q[i] !== (i >= 4)) begin
        bad++;
        $display("FAIL uf_byte%0d got=%02h/%b want=%02h/%b", i, obs_q[i], uf_q[i], exp_q[i], (i >= 4));
      end else $display("underflow byte %0d = %02h uf=%b", i, obs_q[i], uf_q[i]);
    end
    total++;
    if (pop_cnt != 1 || pop_empty != 0) begin
      bad++; $display("FAIL uf_pops got=%0d/%0d want=1/0", pop_cnt, pop_empty);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    do_reset();
    for (int w = 0; w < 8; w++) push_word($urandom);
    init_done = 1'b1;
    observe(130, 0);
    total++;
    d = (vs_rise.size() > 1) ? vs_rise[1] - vs_rise[0] : -1;
    if (d != FRAME) begin bad++; $display("FAIL b2b_vsync_period got=%0d want=%0d", d, FRAME); end
    total++;
    d = (fd_q.size() > 1) ? fd_q[1] - fd_q[0] : -1;
    if (d != FRAME) begin bad++; $display("FAIL b2b_done_period got=%0d want=%0d", d, FRAME); end
    total++;
    if (obs_q.size() != 32) begin bad++; $display("FAIL b2b_count got=%0d want=32", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
      else $display("b2b byte %0d = %02h", i, obs_q[i]);
    end
    total++;
    if (pop_cnt != 8 || underflow !== 1'b0) begin
      bad++; $display("FAIL b2b_pops got=%0d uf=%b want=8 uf=0", pop_cnt, underflow);
    end
  endtask

  task automatic test_init_drop();
    int d;
    do_reset();
    for (int w = 0; w < 4; w++) push_word(32'hA0B0C0D0 + 32'(w));
    init_done = 1'b1;
    observe(140, 29);
    total++;
    if (vs_rise.size() != 1 || fd_q.size() != 1) begin
      bad++; $display("FAIL drop_frames got=%0d/%0d want=1/1", vs_rise.size(), fd_q.size());
    end
    total++;
    d = (fd_q.size() > 0 && vs_rise.size() > 0) ? fd_q[0] - vs_rise[0] : -1;
    if (d != FRAME) begin bad++; $display("FAIL drop_done got=%0d want=%0d", d, FRAME); end
    total++;
    if (obs_q.size() != 16) begin bad++; $display("FAIL drop_count got=%0d want=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
      else $display("drop byte %0d = %02h", i, obs_q[i]);
    end
    total++;
    if ({dvp_vsync, dvp_href} !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b%b want=00", dvp_vsync, dvp_href); end
  endtask

  task automatic test_reset_midline();
    logic [12:0] outs;
    int d;
    do_reset();
    for (int w = 0; w < 4; w++) push_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    init_done = 1'b1;
    observe(29, 0);
    total++;
    if (obs_q.size() != 4) begin bad++; $display("FAIL mid_pre_count got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_pre_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
    end
    rst_n = 1'b0;
    #1;
    outs = {dvp_vsync, dvp_href, dvp_data, frame_done, underflow, rfifo_req};
    total++;
    if (outs !== 13'h0) begin bad++; $display("FAIL mid_async_reset got=%0h want=0", outs); end
    $display("midline reset: outputs=%0h", outs);
    fq.delete();
    repeat (2) @(negedge clk);
    clear_obs();
    for (int w = 0; w < 4; w++) push_word(32'h11223344 * 32'(w + 1));
    rst_n = 1'b1;
    observe(70, 0);
    total++;
    d = (vs_rise.size() > 0) ? vs_rise[0] : -1;
    if (d != 2) begin bad++; $display("FAIL mid_restart got=%0d want=2", d); end
    total++;
    if (obs_q.size() != 16) begin bad++; $display("FAIL mid_count got=%0d want=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_byte%0d got=%02h want=%02h", i, obs_q[i], exp_q[i]); end
      else $display("restart byte %0d = %02h", i, obs_q[i]);
    end
    total++;
    d = (fd_q.size() > 0 && vs_rise.size() > 0) ? fd_q[0] - vs_rise[0] : -1;
    if (d != FRAME || pop_cnt != 4) begin
      bad++; $display("FAIL mid_frame got=%0d pops=%0d want=%0d pops=4", d, pop_cnt, FRAME);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef OV9281_DVP_TX_PATTERN_EN
    test_pattern();
`else
    test_basic();
    test_underflow();
    test_back_to_back();
    test_init_drop();
    test_reset_midline();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
